// File: rtl/instr_encoder_if.sv
// Bus bundles for instr_encoder: the decoded-instruction handshake from the host
// loader, and the write port toward instruction memory.
interface instr_if;
  logic       valid;
  logic       ready;
  logic [2:0] op_class;
  logic       sub;
  logic [1:0] fn;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [4:0] imm;
  logic       last;

  modport master (output valid, op_class, sub, fn, ra, rb, imm, last, input ready);
  modport slave  (input valid, op_class, sub, fn, ra, rb, imm, last, output ready);
endinterface

interface mem_wr_if #(
  parameter int AW = 8
);
  logic          wen;
  logic [AW-1:0] addr;
  logic [8:0]    wdata;
  logic          ready;

  modport master (output wen, addr, wdata, input ready);
  modport slave  (input wen, addr, wdata, output ready);
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded fields into 9-bit ISA words, queues them in a FIFO and
// writes them to consecutive memory addresses. Define INSTR_ENC_RANGE_CHECK_EN to reject out-of-range fields.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  instr_if.slave        in_bus,
  mem_wr_if.master      mem_bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);
  localparam int              PW        = $clog2(DEPTH);
  localparam logic [PW:0]     OCC_FULL  = (PW+1)'(DEPTH);
  localparam logic [PW:0]     OCC_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
  localparam logic [AW-1:0]   ADDR_ONE  = AW'(1);
  localparam logic [AW:0]     COUNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]     COUNT_MAX = '1;

  localparam logic [2:0] OP_LDST  = 3'd0;
  localparam logic [2:0] OP_MOV   = 3'd1;
  localparam logic [2:0] OP_ALU   = 3'd2;
  localparam logic [2:0] OP_SHIFT = 3'd3;
  localparam logic [2:0] OP_JMP   = 3'd4;
  localparam logic [2:0] OP_BLT   = 3'd5;
  localparam logic [2:0] OP_BEQ   = 3'd6;
  localparam logic [2:0] OP_ADDI  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e        state, state_next;
  logic [8:0]    fifo_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_idx;
  logic [PW:0]   occ, occ_next;
  logic [AW-1:0] wr_addr;
  logic [8:0]    word;
  logic          accept, reject, push, pop, start_go, full, wen;

  function automatic logic [8:0] encode(input logic [2:0] op, input logic sub,
                                        input logic [1:0] fn, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [4:0] imm);
    logic [5:0] low;
    low = '0;
    case (op)
      OP_LDST:                low = sub ? {1'b1, ra[1:0], rb} : {1'b0, ra, rb[1:0]};
      OP_MOV, OP_BLT, OP_BEQ: low = {ra, rb};
      // Unary ALU ops carry the sub-op in the Rb slot, so the operands swap places.
      OP_ALU:                 low = (fn == 2'b11) ? {fn, rb[1:0], ra[1:0]} : {fn, ra[1:0], rb[1:0]};
      OP_SHIFT:               low = {ra, imm[2:0]};
      OP_JMP:                 low = sub ? {1'b1, imm} : {2'b00, ra[1:0], rb[1:0]};
      OP_ADDI:                low = {sub, ra[1:0], imm[2:0]};
      default:                low = '0;
    endcase
    return {op, low};
  endfunction

  assign word     = encode(in_bus.op_class, in_bus.sub, in_bus.fn, in_bus.ra, in_bus.rb, in_bus.imm);
  assign full     = (occ == OCC_FULL);
  assign start_go = (state == S_IDLE) && start;
  assign accept   = in_bus.valid && in_bus.ready;
  assign push     = accept && !reject;
  assign pop      = wen && mem_bus.ready;

  assign busy          = (state == S_RUN) || (state == S_DRAIN);
  assign done          = (state == S_DONE);
  assign wen           = busy && (occ != '0);
  assign in_bus.ready  = (state == S_RUN) && !full;
  assign mem_bus.wen   = wen;
  assign mem_bus.addr  = wr_addr;
  assign mem_bus.wdata = wen ? fifo_mem[rd_ptr] : '0;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  function automatic logic field_bad(input logic [2:0] op, input logic sub,
                                     input logic [1:0] fn, input logic [2:0] ra,
                                     input logic [2:0] rb, input logic [4:0] imm);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LDST:  bad = sub ? ra[2] : rb[2];
      OP_ALU:   bad = ra[2] || rb[2] || ((fn == 2'b11) && (rb[1:0] == 2'b11));
      OP_SHIFT: bad = |imm[4:3];
      OP_JMP:   bad = !sub && (ra[2] || rb[2]);
      OP_ADDI:  bad = ra[2] || (|imm[4:3]);
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

  assign reject = field_bad(in_bus.op_class, in_bus.sub, in_bus.fn, in_bus.ra, in_bus.rb, in_bus.imm);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                err <= 1'b0;
    else if (start_go)           err <= 1'b0;
    else if (accept && reject)   err <= 1'b1;
  end
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    occ_next   = occ;
    state_next = state;
    if (push && !pop)      occ_next = occ + OCC_ONE;
    else if (pop && !push) occ_next = occ - OCC_ONE;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (accept && in_bus.last) state_next = S_DRAIN;
      // Look at post-edge occupancy so DONE follows the final write by exactly one edge.
      S_DRAIN: if (occ_next == '0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= word;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      rd_ptr  <= '0;
      wr_idx  <= '0;
      occ     <= '0;
      wr_addr <= '0;
      count   <= '0;
    end else begin
      state <= state_next;
      if (start_go) begin
        rd_ptr  <= '0;
        wr_idx  <= '0;
        occ     <= '0;
        wr_addr <= base_addr;
        count   <= '0;
      end else begin
        occ <= occ_next;
        if (push) wr_idx <= wr_idx + PTR_ONE;
        if (pop) begin
          rd_ptr  <= rd_ptr + PTR_ONE;
          wr_addr <= wr_addr + ADDR_ONE;
          if (count != COUNT_MAX) count <= count + COUNT_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encodings, handshake timing,
// backpressure, address wrap, range handling and asynchronous abort.
module tb_instr_encoder;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy, done, err;
  logic [AW:0]   count;

  instr_if              in_bus();
  mem_wr_if #(.AW(AW))  mem_bus();

  instr_encoder #(.DEPTH(4), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .in_bus    (in_bus.slave),
    .mem_bus   (mem_bus.master),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  logic [AW-1:0] wq_addr [$];
  logic [8:0]    wq_data [$];
  int            wq_edge [$];

  always @(posedge clk) cyc = cyc + 1;

  // Outputs are stable at the falling edge; a handshake seen here commits at the next rising edge.
  always @(negedge clk) begin
    if (mem_bus.wen === 1'b1 && mem_bus.ready === 1'b1) begin
      wq_addr.push_back(mem_bus.addr);
      wq_data.push_back(mem_bus.wdata);
      wq_edge.push_back(cyc + 1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_edge.delete();
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    base_addr = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send_word(input logic [2:0] op, input logic sub, input logic [1:0] fn,
                           input logic [2:0] ra, input logic [2:0] rb, input logic [4:0] imm,
                           input logic last);
    bit ok;
    ok = 0;
    in_bus.op_class = op; in_bus.sub = sub; in_bus.fn = fn;
    in_bus.ra = ra; in_bus.rb = rb; in_bus.imm = imm; in_bus.last = last;
    in_bus.valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_bus.ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!ok) begin
      n_total++;
      $display("FAIL send_word: in_ready never high, got timeout expected accept");
    end
  endtask

  task automatic wait_done(output int cyc_d);
    bit got;
    got   = 0;
    cyc_d = -1;
    in_bus.valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got   = 1;
        cyc_d = cyc;
        break;
      end
    end
    n_total++; if (!got) $display("FAIL done_seen: got 0 expected 1"); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b expected 0", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL busy_after_done: got %b expected 0", busy); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; base_addr = '0;
    in_bus.valid = 1'b0; in_bus.op_class = '0; in_bus.sub = 1'b0; in_bus.fn = '0;
    in_bus.ra = '0; in_bus.rb = '0; in_bus.imm = '0; in_bus.last = 1'b0;
    mem_bus.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (in_bus.ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", in_bus.ready); else n_pass++;
    n_total++; if (mem_bus.wen !== 1'b0) $display("FAIL rst_wen: got %b expected 0", mem_bus.wen); else n_pass++;
    n_total++; if (mem_bus.addr !== 8'h00) $display("FAIL rst_addr: got %h expected 00", mem_bus.addr); else n_pass++;
    n_total++; if (mem_bus.wdata !== 9'h000) $display("FAIL rst_wdata: got %h expected 000", mem_bus.wdata); else n_pass++;
    n_total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL rst_status: got busy=%b done=%b err=%b expected 0 0 0", busy, done, err); else n_pass++;
    n_total++; if (count !== 9'd0) $display("FAIL rst_count: got %0d expected 0", count); else n_pass++;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_basic_program();
    int cyc_d;
    clear_log();
    mem_bus.ready = 1'b1;
    do_start(8'h10);
    n_total++; if (in_bus.ready !== 1'b1 || busy !== 1'b1) $display("FAIL run_entry: got ready=%b busy=%b expected 1 1", in_bus.ready, busy); else n_pass++;
    send_word(3'd7, 1'b0, 2'd0, 3'd2, 3'd0, 5'd5, 1'b0);
    send_word(3'd0, 1'b0, 2'd0, 3'd5, 3'd1, 5'd0, 1'b1);
    wait_done(cyc_d);
    n_total++; if (wq_data.size() != 2) $display("FAIL basic_nwrites: got %0d expected 2", wq_data.size()); else n_pass++;
    if (wq_data.size() == 2) begin
      n_total++; if (wq_addr[0] !== 8'h10 || wq_data[0] !== 9'h1D5) $display("FAIL basic_w0: got %h@%h expected 1d5@10", wq_data[0], wq_addr[0]); else n_pass++;
      n_total++; if (wq_addr[1] !== 8'h11 || wq_data[1] !== 9'h015) $display("FAIL basic_w1: got %h@%h expected 015@11", wq_data[1], wq_addr[1]); else n_pass++;
      n_total++; if (cyc_d != wq_edge[1]) $display("FAIL basic_done_timing: got edge %0d expected %0d", cyc_d, wq_edge[1]); else n_pass++;
    end
    n_total++; if (count !== 9'd2) $display("FAIL basic_count: got %0d expected 2", count); else n_pass++;
  endtask

  task automatic test_encoding_back_to_back();
    int cyc_d;
    logic [8:0] exp_data [4];
    exp_data[0] = 9'h133; exp_data[1] = 9'h03E; exp_data[2] = 9'h0B6; exp_data[3] = 9'h1A7;
    clear_log();
    mem_bus.ready = 1'b1;
    do_start(8'h20);
    send_word(3'd4, 1'b1, 2'd0, 3'd0, 3'd0, 5'h13, 1'b0);
    send_word(3'd0, 1'b1, 2'd0, 3'd3, 3'd6, 5'd0,  1'b0);
    send_word(3'd2, 1'b0, 2'd3, 3'd2, 3'd1, 5'd0,  1'b0);
    send_word(3'd6, 1'b0, 2'd0, 3'd4, 3'd7, 5'd0,  1'b1);
    wait_done(cyc_d);
    n_total++; if (wq_data.size() != 4) $display("FAIL enc_nwrites: got %0d expected 4", wq_data.size()); else n_pass++;
    if (wq_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (wq_data[i] !== exp_data[i] || wq_addr[i] !== 8'(8'h20 + i))
          $display("FAIL enc_w%0d: got %h@%h expected %h@%h", i, wq_data[i], wq_addr[i], exp_data[i], 8'(8'h20 + i));
        else n_pass++;
      end
      n_total++; if (wq_edge[3] - wq_edge[0] != 3) $display("FAIL enc_throughput: got %0d edges expected 3", wq_edge[3] - wq_edge[0]); else n_pass++;
    end
    n_total++; if (count !== 9'd4) $display("FAIL enc_count: got %0d expected 4", count); else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc_d;
    logic [8:0] exp_data [5];
    exp_data[0] = 9'h047; exp_data[1] = 9'h04E; exp_data[2] = 9'h055; exp_data[3] = 9'h05C; exp_data[4] = 9'h063;
    clear_log();
    mem_bus.ready = 1'b0;
    do_start(8'h40);
    for (int i = 0; i < 4; i++) send_word(3'd1, 1'b0, 2'd0, 3'(i), 3'(7 - i), 5'd0, 1'b0);
    in_bus.op_class = 3'd1; in_bus.ra = 3'd4; in_bus.rb = 3'd3; in_bus.last = 1'b1; in_bus.valid = 1'b1;
    @(negedge clk);
    n_total++; if (in_bus.ready !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", in_bus.ready); else n_pass++;
    n_total++; if (mem_bus.wen !== 1'b1 || mem_bus.addr !== 8'h40 || mem_bus.wdata !== 9'h047) $display("FAIL bp_stall_a: got wen=%b %h@%h expected 1 047@40", mem_bus.wen, mem_bus.wdata, mem_bus.addr); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (mem_bus.wen !== 1'b1 || mem_bus.addr !== 8'h40 || mem_bus.wdata !== 9'h047) $display("FAIL bp_stall_b: got wen=%b %h@%h expected 1 047@40", mem_bus.wen, mem_bus.wdata, mem_bus.addr); else n_pass++;
    n_total++; if (in_bus.ready !== 1'b0 || count !== 9'd0) $display("FAIL bp_stall_state: got ready=%b count=%0d expected 0 0", in_bus.ready, count); else n_pass++;
    @(posedge clk); #1;
    mem_bus.ready = 1'b1;
    send_word(3'd1, 1'b0, 2'd0, 3'd4, 3'd3, 5'd0, 1'b1);
    wait_done(cyc_d);
    n_total++; if (wq_data.size() != 5) $display("FAIL bp_nwrites: got %0d expected 5", wq_data.size()); else n_pass++;
    if (wq_data.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        n_total++;
        if (wq_data[i] !== exp_data[i] || wq_addr[i] !== 8'(8'h40 + i))
          $display("FAIL bp_w%0d: got %h@%h expected %h@%h", i, wq_data[i], wq_addr[i], exp_data[i], 8'(8'h40 + i));
        else n_pass++;
      end
    end
    n_total++; if (count !== 9'd5) $display("FAIL bp_count: got %0d expected 5", count); else n_pass++;
  endtask

  task automatic test_wrap();
    int cyc_d;
    clear_log();
    mem_bus.ready = 1'b1;
    do_start(8'hFF);
    n_total++; if (err !== 1'b0 || count !== 9'd0) $display("FAIL wrap_start_clear: got err=%b count=%0d expected 0 0", err, count); else n_pass++;
    send_word(3'd3, 1'b0, 2'd0, 3'd1, 3'd0, 5'd3, 1'b0);
    send_word(3'd1, 1'b0, 2'd0, 3'd0, 3'd0, 5'd0, 1'b1);
    wait_done(cyc_d);
    n_total++; if (wq_data.size() != 2) $display("FAIL wrap_nwrites: got %0d expected 2", wq_data.size()); else n_pass++;
    if (wq_data.size() == 2) begin
      n_total++; if (wq_addr[0] !== 8'hFF || wq_data[0] !== 9'h0CB) $display("FAIL wrap_w0: got %h@%h expected 0cb@ff", wq_data[0], wq_addr[0]); else n_pass++;
      n_total++; if (wq_addr[1] !== 8'h00 || wq_data[1] !== 9'h040) $display("FAIL wrap_w1: got %h@%h expected 040@00", wq_data[1], wq_addr[1]); else n_pass++;
    end
    n_total++; if (count !== 9'd2) $display("FAIL wrap_count: got %0d expected 2", count); else n_pass++;
  endtask

  task automatic test_range();
    int cyc_d;
    clear_log();
    mem_bus.ready = 1'b1;
    do_start(8'h80);
    send_word(3'd7, 1'b0, 2'd0, 3'd0, 3'd0, 5'd9, 1'b1);
    wait_done(cyc_d);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    n_total++; if (wq_data.size() != 0) $display("FAIL range_nwrites: got %0d expected 0", wq_data.size()); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL range_err: got %b expected 1", err); else n_pass++;
    n_total++; if (count !== 9'd0) $display("FAIL range_count: got %0d expected 0", count); else n_pass++;
`else
    n_total++; if (wq_data.size() != 1) $display("FAIL range_nwrites: got %0d expected 1", wq_data.size()); else n_pass++;
    if (wq_data.size() == 1) begin
      n_total++; if (wq_addr[0] !== 8'h80 || wq_data[0] !== 9'h1C1) $display("FAIL range_w0: got %h@%h expected 1c1@80", wq_data[0], wq_addr[0]); else n_pass++;
    end
    n_total++; if (err !== 1'b0) $display("FAIL range_err: got %b expected 0", err); else n_pass++;
    n_total++; if (count !== 9'd1) $display("FAIL range_count: got %0d expected 1", count); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_drain();
    int n_before;
    clear_log();
    mem_bus.ready = 1'b0;
    do_start(8'h00);
    send_word(3'd1, 1'b0, 2'd0, 3'd1, 3'd2, 5'd0, 1'b0);
    send_word(3'd1, 1'b0, 2'd0, 3'd3, 3'd4, 5'd0, 1'b0);
    send_word(3'd1, 1'b0, 2'd0, 3'd5, 3'd6, 5'd0, 1'b1);
    in_bus.valid = 1'b0;
    n_total++; if (busy !== 1'b1 || in_bus.ready !== 1'b0 || mem_bus.wen !== 1'b1) $display("FAIL drain_state: got busy=%b ready=%b wen=%b expected 1 0 1", busy, in_bus.ready, mem_bus.wen); else n_pass++;
    n_before = wq_data.size();
    reset_n = 1'b0;
    mem_bus.ready = 1'b1;
    #1;
    n_total++; if (mem_bus.wen !== 1'b0 || mem_bus.addr !== 8'h00 || mem_bus.wdata !== 9'h000) $display("FAIL abort_mem: got wen=%b %h@%h expected 0 000@00", mem_bus.wen, mem_bus.wdata, mem_bus.addr); else n_pass++;
    n_total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || in_bus.ready !== 1'b0 || count !== 9'd0) $display("FAIL abort_status: got busy=%b done=%b err=%b ready=%b count=%0d expected all 0", busy, done, err, in_bus.ready, count); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_total++; if (wq_data.size() != n_before) $display("FAIL abort_no_write: got %0d writes expected %0d", wq_data.size(), n_before); else n_pass++;
    n_total++; if (mem_bus.wen !== 1'b0 || busy !== 1'b0) $display("FAIL abort_idle: got wen=%b busy=%b expected 0 0", mem_bus.wen, busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_program();
    test_encoding_back_to_back();
    test_backpressure();
    test_wrap();
    test_range();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
